// File: rtl/zero_shift_unit.sv
// Iterative shift/rotate unit: SHL/SHR/SAR/ROL/ROR, up to STEP bit positions per cycle,
// valid/ready handshake on request and result sides.
module zero_shift_unit #(
  parameter int WIDTH    = 12,
  parameter int AMT_BITS = 12,
  parameter int STEP     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [WIDTH-1:0]    in_value,
  input  logic [AMT_BITS-1:0] in_amount,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_carry,
  output logic                out_zero,
  output logic                out_error,
  output logic [31:0]         op_count
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam int XW = AMT_BITS + 32;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SAR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [WIDTH-1:0]  value_reg;
  logic [RW-1:0]     remaining_reg;
  logic              carry_reg;
  logic              error_reg;
  logic [31:0]       count_reg;

  logic [XW-1:0]     amt_wide;
  logic [RW-1:0]     eff_amount;
  logic              op_legal;
  logic [RW-1:0]     step_amt;
  logic [STEP*WIDTH-1:0] cand_val;
  logic [STEP-1:0]   cand_carry;
  logic [WIDTH-1:0]  shifted;
  logic              shift_carry;

  assign amt_wide = XW'(in_amount);

  // Effective distance: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH.
  always_comb begin
    eff_amount = '0;
    op_legal   = 1'b1;
    case (in_op)
      OP_SHL, OP_SHR, OP_SAR:
        eff_amount = (amt_wide >= XW'(WIDTH)) ? RW'(WIDTH) : RW'(amt_wide);
      OP_ROL, OP_ROR:
        eff_amount = RW'(amt_wide % XW'(WIDTH));
      default:
        op_legal = 1'b0;
    endcase
  end

  assign step_amt = (remaining_reg < RW'(STEP)) ? remaining_reg : RW'(STEP);

  // One candidate per possible per-cycle distance; the live one is picked below.
  genvar gi;
  generate
    for (gi = 1; gi <= STEP; gi++) begin : g_step
      assign cand_val[(gi-1)*WIDTH +: WIDTH] =
          (op_reg == OP_SHL) ? (value_reg << gi) :
          (op_reg == OP_SHR) ? (value_reg >> gi) :
          (op_reg == OP_SAR) ? WIDTH'($signed(value_reg) >>> gi) :
          (op_reg == OP_ROL) ? ((value_reg << gi) | (value_reg >> (WIDTH - gi))) :
          (op_reg == OP_ROR) ? ((value_reg >> gi) | (value_reg << (WIDTH - gi))) :
                               value_reg;
      assign cand_carry[gi-1] =
          (op_reg == OP_SHL || op_reg == OP_ROL) ? value_reg[WIDTH - gi] :
          (op_reg == OP_ROR)                     ? value_reg[0] :
                                                   value_reg[gi - 1];
    end
  endgenerate

  always_comb begin
    shifted     = value_reg;
    shift_carry = 1'b0;
    for (int k = 0; k < STEP; k++) begin
      if (step_amt == RW'(k + 1)) begin
        shifted     = cand_val[k*WIDTH +: WIDTH];
        shift_carry = cand_carry[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:
        if (in_valid)
          state_next = (op_legal && eff_amount != '0) ? SHIFT : DONE;
      SHIFT:
        if (remaining_reg == step_amt)
          state_next = DONE;
      DONE:
        if (out_ready)
          state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      value_reg     <= '0;
      remaining_reg <= '0;
      carry_reg     <= 1'b0;
      error_reg     <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE:
          if (in_valid) begin
            op_reg        <= in_op;
            value_reg     <= in_value;
            remaining_reg <= op_legal ? eff_amount : '0;
            carry_reg     <= 1'b0;
            error_reg     <= !op_legal;
          end
        SHIFT: begin
          value_reg     <= shifted;
          carry_reg     <= shift_carry;
          remaining_reg <= remaining_reg - step_amt;
        end
        DONE:
          if (out_ready)
            count_reg <= count_reg + 32'd1;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = value_reg;
  assign out_carry  = carry_reg;
  assign out_zero   = (value_reg == '0);
  assign out_error  = error_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_zero_shift_unit.sv
// Directed bench for zero_shift_unit (WIDTH=12, STEP=4): vector table plus backpressure
// and mid-operation reset sequences.
module tb_zero_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [11:0] in_value;
  logic [11:0] in_amount;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_error;
  logic [31:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_count = 0;

  always #5 clock = ~clock;

  zero_shift_unit #(.WIDTH(12), .AMT_BITS(12), .STEP(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_value(in_value), .in_amount(in_amount),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_error(out_error),
    .op_count(op_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [11:0] value;
    logic [11:0] amount;
    logic [11:0] res;
    logic        carry;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, measure latency, check result, then hand it off.
  task automatic run_op(input vec_t v);
    int lat;
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_value  = v.value;
    in_amount = v.amount;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      in_value  = 12'h000;
      in_amount = 12'h000;
      lat++;
    end while (!out_valid && lat < 40);
    $display("op=%0d value=%03h amount=%0d -> result=%03h carry=%0b zero=%0b error=%0b latency=%0d",
             v.op, v.value, v.amount, out_result, out_carry, out_zero, out_error, lat);
    check("latency", 32'(lat), 32'(v.lat));
    check("result", 32'(out_result), 32'(v.res));
    check("carry", 32'(out_carry), 32'(v.carry));
    check("zero", 32'(out_zero), 32'(v.zero));
    check("error", 32'(out_error), 32'(v.err));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    exp_count++;
    check("op_count", op_count, 32'(exp_count));
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [11:0] held;
    int w;

    vecs[0]  = '{3'd0, 12'h001, 12'd1,    12'h002, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{3'd2, 12'h800, 12'd13,   12'hFFF, 1'b1, 1'b0, 1'b0, 4};
    vecs[2]  = '{3'd3, 12'h801, 12'd4,    12'h018, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{3'd4, 12'h801, 12'd16,   12'h180, 1'b1, 1'b0, 1'b0, 2};
    vecs[4]  = '{3'd1, 12'hABC, 12'd0,    12'hABC, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd6, 12'h5A5, 12'd3,    12'h5A5, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'd0, 12'h123, 12'd12,   12'h000, 1'b1, 1'b1, 1'b0, 4};
    vecs[7]  = '{3'd1, 12'h923, 12'd12,   12'h000, 1'b1, 1'b1, 1'b0, 4};
    vecs[8]  = '{3'd1, 12'hABC, 12'd5,    12'h055, 1'b1, 1'b0, 1'b0, 3};
    vecs[9]  = '{3'd2, 12'h8F0, 12'd2,    12'hE3C, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{3'd3, 12'h923, 12'd13,   12'h247, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{3'd3, 12'h001, 12'd12,   12'h001, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{3'd0, 12'hFFF, 12'd4095, 12'h000, 1'b1, 1'b1, 1'b0, 4};
    vecs[13] = '{3'd2, 12'h7FF, 12'd12,   12'h000, 1'b0, 1'b1, 1'b0, 4};
    vecs[14] = '{3'd3, 12'h801, 12'd6,    12'h060, 1'b0, 1'b0, 1'b0, 3};
    vecs[15] = '{3'd7, 12'h000, 12'd1,    12'h000, 1'b0, 1'b1, 1'b1, 1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_value  = 12'h000;
    in_amount = 12'h000;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(out_result), 32'd0);
    check("reset_carry", 32'(out_carry), 32'd0);
    check("reset_zero", 32'(out_zero), 32'd1);
    check("reset_error", 32'(out_error), 32'd0);
    check("reset_op_count", op_count, 32'd0);

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Backpressure: result must hold and junk requests must be ignored while in DONE.
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_value  = 12'h00F;
    in_amount = 12'd3;
    w = 0;
    do begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      w++;
    end while (!out_valid && w < 40);
    check("bp_valid", 32'(out_valid), 32'd1);
    held = out_result;
    check("bp_result", 32'(held), 32'h078);
    in_valid  = 1'b1;
    in_op     = 3'd1;
    in_value  = 12'hFFF;
    in_amount = 12'd1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", 32'(out_result), 32'h078);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_count", op_count, 32'(exp_count));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    exp_count++;
    $display("backpressure op: result=%03h released, op_count=%0d", held, op_count);
    check("bp_release_count", op_count, 32'(exp_count));
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset while an SAR is partway through SHIFT.
    in_valid  = 1'b1;
    in_op     = 3'd2;
    in_value  = 12'h800;
    in_amount = 12'd12;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("mid_in_shift", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    $display("reset mid-shift: in_ready=%0b out_valid=%0b op_count=%0d", in_ready, out_valid, op_count);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_count", op_count, 32'd0);
    check("rst_zero", 32'(out_zero), 32'd1);
    exp_count = 0;
    @(posedge clock);
    #1;
    check("rst_idle_hold", 32'(out_valid), 32'd0);
    v = '{3'd4, 12'h801, 12'd16, 12'h180, 1'b1, 1'b0, 1'b0, 2};
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
